// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared I2C constants and target FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    localparam logic       c_ACK        = 1'b0;
    localparam logic       c_NACK       = 1'b1;
    localparam logic [6:0] c_SLAVE_ADDR = 7'h50;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV_ADDR = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_PTR_BYTE = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WR_BYTE  = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_RD_BYTE  = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } i2c_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronizers with edge and START/STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_s,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    // [1:0] synchronizer, [2] history; reset to the idle-high bus level
    logic [2:0] r_scl_pipe;
    logic [2:0] r_sda_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_pipe <= 3'b111;
            r_sda_pipe <= 3'b111;
        end else begin
            r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
            r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
        end
    end

    logic w_scl_s, w_scl_prev, w_sda_s, w_sda_prev;
    assign w_scl_s    = r_scl_pipe[1];
    assign w_scl_prev = r_scl_pipe[2];
    assign w_sda_s    = r_sda_pipe[1];
    assign w_sda_prev = r_sda_pipe[2];

    assign o_sda_s     = w_sda_s;
    assign o_scl_rise  =  w_scl_s & ~w_scl_prev;
    assign o_scl_fall  = ~w_scl_s &  w_scl_prev;
    assign o_start_det =  w_scl_s &  w_scl_prev &  w_sda_prev & ~w_sda_s;
    assign o_stop_det  =  w_scl_s &  w_scl_prev & ~w_sda_prev &  w_sda_s;

endmodule
`default_nettype wire

// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_eeprom_slave
// Description : 256-byte EEPROM-style I2C target with auto-increment pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = c_SLAVE_ADDR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [7:0] ptr
);

    logic w_sda_s, w_scl_rise, w_scl_fall, w_start_det, w_stop_det;

    i2c_bus_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_scl       (scl),
        .i_sda       (sda),
        .o_sda_s     (w_sda_s),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det)
    );

    i2c_state_t r_state, w_state_nxt;
    logic [3:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0] r_shreg, w_shreg_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_wr_valid, w_wr_valid_nxt;
    logic [7:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0] r_wr_data, w_wr_data_nxt;
    logic       r_rd_valid, w_rd_valid_nxt;
    logic [7:0] r_ptr, w_ptr_nxt;
    logic       w_mem_we;
    logic [7:0] r_mem [0:255];
    logic [7:0] w_mem_rd;

    assign w_mem_rd = r_mem[r_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shreg    <= 8'h00;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_ptr      <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_valid <= w_wr_valid_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_ptr      <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) r_mem[i] <= 8'h00;
        end else if (w_mem_we) begin
            r_mem[r_ptr] <= r_shreg;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shreg_nxt    = r_shreg;
        w_sda_oe_nxt   = r_sda_oe;
        w_busy_nxt     = r_busy;
        w_wr_valid_nxt = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_rd_valid_nxt = 1'b0;
        w_ptr_nxt      = r_ptr;
        w_mem_we       = 1'b0;

        if (w_stop_det) begin
            w_state_nxt  = ST_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start_det) begin
            w_state_nxt   = ST_DEV_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_oe_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_DEV_ADDR, ST_PTR_BYTE, ST_WR_BYTE: begin
                    // the 9th clock belongs to the ACK state, so never shift past 8
                    if (w_scl_rise && r_bit_cnt != 4'd8) begin
                        w_shreg_nxt   = {r_shreg[6:0], w_sda_s};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                        if (r_state == ST_DEV_ADDR && r_shreg[7:1] != SLAVE_ADDR) begin
                            w_state_nxt = ST_IGNORE;
                            w_busy_nxt  = 1'b0;
                        end else begin
                            w_sda_oe_nxt = 1'b1;
                            case (r_state)
                                ST_DEV_ADDR: begin
                                    w_state_nxt = ST_DEV_ACK;
                                    w_busy_nxt  = 1'b1;
                                end
                                ST_PTR_BYTE: begin
                                    w_state_nxt = ST_PTR_ACK;
                                    w_ptr_nxt   = r_shreg;
                                end
                                default: w_state_nxt = ST_WR_ACK;
                            endcase
                        end
                    end
                end
                ST_DEV_ACK: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 4'd0;
                        if (r_shreg[0] == 1'b0) begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = ST_PTR_BYTE;
                        end else begin
                            w_shreg_nxt    = w_mem_rd;
                            w_rd_valid_nxt = 1'b1;
                            w_sda_oe_nxt   = ~w_mem_rd[7];
                            w_state_nxt    = ST_RD_BYTE;
                        end
                    end
                end
                ST_PTR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = ST_WR_BYTE;
                    end
                end
                ST_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt   = 1'b0;
                        w_bit_cnt_nxt  = 4'd0;
                        w_mem_we       = 1'b1;
                        w_wr_valid_nxt = 1'b1;
                        w_wr_addr_nxt  = r_ptr;
                        w_wr_data_nxt  = r_shreg;
                        w_ptr_nxt      = r_ptr + 8'd1;
                        w_state_nxt    = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_bit_cnt_nxt = 4'd8;
                            w_state_nxt   = ST_RD_ACK;
                        end else begin
                            w_shreg_nxt   = {r_shreg[6:0], 1'b0};
                            w_sda_oe_nxt  = ~r_shreg[6];
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    // bit_cnt 8: awaiting master's bit; 9: master ACKed, load on fall
                    if (w_scl_rise && r_bit_cnt == 4'd8) begin
                        w_ptr_nxt     = r_ptr + 8'd1;
                        w_bit_cnt_nxt = 4'd9;
                        if (w_sda_s == c_NACK) w_state_nxt = ST_IGNORE;
                    end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                        w_shreg_nxt    = w_mem_rd;
                        w_rd_valid_nxt = 1'b1;
                        w_sda_oe_nxt   = ~w_mem_rd[7];
                        w_bit_cnt_nxt  = 4'd0;
                        w_state_nxt    = ST_RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda      = r_sda_oe ? 1'b0 : 1'bz;
    assign busy     = r_busy;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_valid = r_rd_valid;
    assign ptr      = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_eeprom_slave
// Description : Bit-banged I2C master bench with a byte-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_eeprom_slave;

    localparam int c_Q = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv_low = 1'b0;
    wire        sda_bus;
    logic       busy, wr_valid, rd_valid;
    logic [7:0] wr_addr, wr_data, ptr;

    pullup (sda_bus);
    assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;

    i2c_eeprom_slave dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl_drv),
        .sda      (sda_bus),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .ptr      (ptr)
    );

    always #5 clk = ~clk;

    logic [15:0] wr_log [$];
    int          rd_cnt = 0;

    always @(negedge clk) begin
        if (wr_valid) wr_log.push_back({wr_addr, wr_data});
        if (rd_valid) rd_cnt++;
    end

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] m_mem [256];
    logic [7:0] m_ptr = 8'h00;
    logic [7:0] buf_d [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start;
        sda_drv_low = 1'b0; #c_Q;
        scl_drv = 1'b1;     #c_Q;
        sda_drv_low = 1'b1; #c_Q;
        scl_drv = 1'b0;     #c_Q;
    endtask

    task automatic bus_stop;
        sda_drv_low = 1'b1; #c_Q;
        scl_drv = 1'b1;     #c_Q;
        sda_drv_low = 1'b0; #(2 * c_Q);
    endtask

    task automatic bus_bit(input logic b, output logic sampled);
        sda_drv_low = ~b; #c_Q;
        scl_drv = 1'b1;   #c_Q;
        sampled = sda_bus; #c_Q;
        scl_drv = 1'b0;   #c_Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
        bus_bit(master_ack, s);
    endtask

    task automatic settle;
        repeat (6) @(negedge clk);
    endtask

    // Write n bytes from buf_d starting at wptr, then check every side effect.
    task automatic do_write(input string tag, input logic [7:0] wptr, input int n);
        logic a;
        int   base;
        logic [15:0] exp_q [$];
        base = wr_log.size();
        bus_start;
        write_byte(8'hA0, a);
        check({tag, "_addr_ack"}, a, 0);
        check({tag, "_busy"}, busy, 1);
        write_byte(wptr, a);
        check({tag, "_ptr_ack"}, a, 0);
        m_ptr = wptr;
        for (int i = 0; i < n; i++) begin
            write_byte(buf_d[i], a);
            check({tag, "_data_ack"}, a, 0);
            m_mem[m_ptr] = buf_d[i];
            exp_q.push_back({m_ptr, buf_d[i]});
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop;
        settle;
        check({tag, "_wr_count"}, wr_log.size() - base, n);
        for (int i = 0; i < n && base + i < wr_log.size(); i++)
            check({tag, "_wr_event"}, wr_log[base + i], exp_q[i]);
        check({tag, "_ptr_after"}, ptr, m_ptr);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // Random read: pointer write, repeated START, n bytes with NACK on the last.
    task automatic do_read(input string tag, input logic [7:0] rptr, input int n);
        logic       a;
        logic [7:0] d;
        int         base;
        base = rd_cnt;
        bus_start;
        write_byte(8'hA0, a);
        check({tag, "_addr_ack"}, a, 0);
        write_byte(rptr, a);
        check({tag, "_ptr_ack"}, a, 0);
        bus_start;
        write_byte(8'hA1, a);
        check({tag, "_raddr_ack"}, a, 0);
        m_ptr = rptr;
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
            check({tag, "_rd_data"}, d, m_mem[m_ptr]);
            m_ptr = m_ptr + 8'd1;
        end
        bus_stop;
        settle;
        check({tag, "_rd_count"}, rd_cnt - base, n);
        check({tag, "_ptr_after"}, ptr, m_ptr);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        logic       a;
        logic       s;
        int         n;
        logic [7:0] rp;
        int         base;

        foreach (m_mem[i]) m_mem[i] = 8'h00;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        settle;

        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_ptr", ptr, 0);
        check("rst_sda", sda_bus, 1);

        buf_d[0] = 8'h3C; buf_d[1] = 8'h5A;
        do_write("seq_wr", 8'h10, 2);
        do_read("rand_rd", 8'h10, 2);

        // Address mismatch
        base = wr_log.size();
        bus_start;
        write_byte(8'hA2, a);
        check("mis_addr_nack", a, 1);
        check("mis_busy", busy, 0);
        write_byte(8'h00, a);
        check("mis_byte_nack", a, 1);
        bus_stop;
        settle;
        check("mis_no_wr", wr_log.size() - base, 0);
        check("mis_busy_after", busy, 0);
        do_read("mis_mem", 8'h00, 1);

        buf_d[0] = 8'h11; buf_d[1] = 8'h22;
        do_write("wrap_wr", 8'hFF, 2);
        do_read("wrap_rd", 8'hFF, 2);

        // STOP after four data bits
        base = wr_log.size();
        bus_start;
        write_byte(8'hA0, a);
        write_byte(8'h20, a);
        check("stopmid_ptr_ack", a, 0);
        for (int i = 7; i >= 4; i--) bus_bit(buf_d[0][i], s);
        bus_stop;
        settle;
        check("stopmid_no_wr", wr_log.size() - base, 0);
        check("stopmid_ptr", ptr, 8'h20);
        check("stopmid_busy", busy, 0);
        buf_d[0] = 8'(($urandom));
        do_write("after_stop", 8'h21, 1);
        do_read("after_stop_rd", 8'h20, 2);

        for (int it = 0; it < 4; it++) begin
            rp = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) buf_d[i] = 8'($urandom);
            do_write("rnd_wr", rp, n);
            do_read("rnd_rd", rp, n);
        end

        // Reset while the target drives a 0 data bit
        buf_d[0] = 8'h3C;
        do_write("pre_rst", 8'h10, 1);
        bus_start;
        write_byte(8'hA0, a);
        write_byte(8'h10, a);
        bus_start;
        write_byte(8'hA1, a);
        check("rst_mid_rd_ack", a, 0);
        check("rst_mid_sda_driven", sda_bus, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_sda_released", sda_bus, 1);
        check("rst_mid_ptr", ptr, 0);
        sda_drv_low = 1'b0;
        scl_drv = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 8'h00;
        m_ptr = 8'h00;
        settle;
        check("rst_mid_busy", busy, 0);
        do_read("rst_mem", 8'h10, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
